// File: rtl/tug_of_war_referee.sv
// Tug-of-war game referee: turns key presses into field move pulses, detects
// round wins at the field edges, keeps scores and declares the game winner.
module tug_of_war_referee #(
    parameter int unsigned SCORE_W     = 3,
    parameter int unsigned SCORE_MAX   = 7,
    parameter int unsigned ARM_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned TIMER_W     = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               KeyL,
    input  logic               KeyR,
    input  logic               EdgeL,
    input  logic               EdgeR,
    output logic               L,
    output logic               R,
    output logic               FieldReset,
    output logic               winL,
    output logic               winR,
    output logic [SCORE_W-1:0] scoreL,
    output logic [SCORE_W-1:0] scoreR,
    output logic               gameOver
);

    typedef enum logic [2:0] {CLEAR, ARM, PLAY, WIN, OVER} state_t;

    localparam logic [TIMER_W-1:0] ARM_LOAD  = TIMER_W'(ARM_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [SCORE_W-1:0] score_l_next, score_r_next, win_score;
    logic               prev_l, prev_r;
    logic               press_l, press_r, solo_l, solo_r, tie;
    logic               l_next, r_next, win_l_next, win_r_next, game_over_next;

    assign press_l   = KeyL & ~prev_l;
    assign press_r   = KeyR & ~prev_r;
    assign solo_l    = press_l & ~press_r;
    assign solo_r    = press_r & ~press_l;
    assign tie       = press_l & press_r;
    assign win_score = winL ? scoreL : scoreR;

    assign FieldReset = (state == CLEAR);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= CLEAR;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR: state_next = ARM;
            ARM:   if (timer == '0) state_next = PLAY;
            PLAY:  if ((solo_l && EdgeL) || (solo_r && EdgeR)) state_next = WIN;
            WIN:   if (timer == '0) state_next = (win_score == SCORE_TOP) ? OVER : CLEAR;
            OVER:  if (tie) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    // Next values of the registered outputs, scores and the shared timer.
    always_comb begin
        timer_next     = timer;
        l_next         = 1'b0;
        r_next         = 1'b0;
        win_l_next     = winL;
        win_r_next     = winR;
        score_l_next   = scoreL;
        score_r_next   = scoreR;
        game_over_next = gameOver;
        case (state)
            CLEAR: timer_next = ARM_LOAD;
            ARM:   if (timer != '0) timer_next = timer - 1'b1;
            PLAY: begin
                if (solo_l) begin
                    if (EdgeL) begin
                        win_l_next   = 1'b1;
                        score_l_next = (scoreL == '1) ? scoreL : scoreL + 1'b1;
                        timer_next   = HOLD_LOAD;
                    end else begin
                        l_next = 1'b1;
                    end
                end else if (solo_r) begin
                    if (EdgeR) begin
                        win_r_next   = 1'b1;
                        score_r_next = (scoreR == '1) ? scoreR : scoreR + 1'b1;
                        timer_next   = HOLD_LOAD;
                    end else begin
                        r_next = 1'b1;
                    end
                end
            end
            WIN: begin
                if (timer != '0) begin
                    timer_next = timer - 1'b1;
                end else if (win_score == SCORE_TOP) begin
                    game_over_next = 1'b1;
                end else begin
                    win_l_next = 1'b0;
                    win_r_next = 1'b0;
                end
            end
            OVER: begin
                if (tie) begin
                    score_l_next   = '0;
                    score_r_next   = '0;
                    win_l_next     = 1'b0;
                    win_r_next     = 1'b0;
                    game_over_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Previous-key registers reset high so keys held through reset are not presses.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            timer    <= '0;
            prev_l   <= 1'b1;
            prev_r   <= 1'b1;
            L        <= 1'b0;
            R        <= 1'b0;
            winL     <= 1'b0;
            winR     <= 1'b0;
            scoreL   <= '0;
            scoreR   <= '0;
            gameOver <= 1'b0;
        end else begin
            timer    <= timer_next;
            prev_l   <= KeyL;
            prev_r   <= KeyR;
            L        <= l_next;
            R        <= r_next;
            winL     <= win_l_next;
            winR     <= win_r_next;
            scoreL   <= score_l_next;
            scoreR   <= score_r_next;
            gameOver <= game_over_next;
        end
    end

endmodule

// File: tb/tb_tug_of_war_referee.sv
// Directed self-checking bench for tug_of_war_referee; inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
module tb_tug_of_war_referee;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_l, key_r, edge_l, edge_r;
    logic       l, r, field_reset, win_l, win_r, game_over;
    logic [2:0] score_l, score_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tug_of_war_referee #(
        .SCORE_W(3), .SCORE_MAX(7), .ARM_CYCLES(4), .HOLD_CYCLES(16), .TIMER_W(8)
    ) dut (
        .Clock(clk), .Reset(rst_n), .KeyL(key_l), .KeyR(key_r),
        .EdgeL(edge_l), .EdgeR(edge_r), .L(l), .R(r), .FieldReset(field_reset),
        .winL(win_l), .winR(win_r), .scoreL(score_l), .scoreR(score_r),
        .gameOver(game_over)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; key_l = 1'b1; key_r = 1'b0; edge_l = 1'b0; edge_r = 1'b0;
        #1;
        check("rst_field_reset", field_reset, 1);
        check("rst_l", l, 0);
        check("rst_win_l", win_l, 0);
        check("rst_score_l", score_l, 0);
        check("rst_game_over", game_over, 0);
        step(); step();
        rst_n = 1'b1;
        check("clear_field_reset", field_reset, 1);
        // CLEAR -> ARM, then 4 ARM cycles with KeyL still held from reset
        step();
        check("arm_field_reset", field_reset, 0);
        check("held_key_l", l, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("arm_no_l", l, 0);
            check("arm_no_fr", field_reset, 0);
        end
        key_l = 1'b0; step();
        key_l = 1'b1; step();
        check("first_press_l", l, 1);
        check("first_press_r", r, 0);
        step();
        check("first_press_l_off", l, 0);
        key_l = 1'b0; step();

        // separate presses, then a long hold
        for (int i = 0; i < 3; i++) begin
            key_l = 1'b1; step();
            check("press_l_pulse", l, 1);
            key_l = 1'b0; step();
            check("press_l_end", l, 0);
        end
        key_l = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            pulses += int'(l);
        end
        check("hold_one_pulse", pulses, 1);
        key_l = 1'b0; step();

        // tie press is discarded
        key_l = 1'b1; key_r = 1'b1; step();
        check("tie_l", l, 0);
        check("tie_r", r, 0);
        check("tie_score_l", score_l, 0);
        check("tie_score_r", score_r, 0);
        key_l = 1'b0; key_r = 1'b0; step();
        check("tie_win_r", win_r, 0);

        // right wins a round
        edge_r = 1'b1; key_r = 1'b1; step();
        check("win_r", win_r, 1);
        check("win_r_score", score_r, 1);
        check("win_r_no_pulse", r, 0);
        key_r = 1'b0; edge_r = 1'b0; edge_l = 1'b1;
        for (int i = 0; i < 15; i++) begin
            key_l = (i == 3 || i == 7);
            step();
            check("win_hold", win_r, 1);
            check("win_no_l", l, 0);
            check("win_no_fr", field_reset, 0);
        end
        key_l = 1'b0; edge_l = 1'b0;
        step();
        check("win_end", win_r, 0);
        check("win_end_fr", field_reset, 1);
        check("win_score_l", score_l, 0);

        // presses during ARM are ignored
        step();
        key_l = 1'b1; step(); check("arm_press_a", l, 0);
        key_l = 1'b0; step(); check("arm_press_b", l, 0);
        key_l = 1'b1; step(); check("arm_press_c", l, 0);
        key_l = 1'b0; step();
        check("arm_score_l", score_l, 0);
        check("arm_score_r", score_r, 1);

        // left wins seven rounds
        for (int k = 1; k <= 7; k++) begin
            edge_l = 1'b1; key_l = 1'b1; step();
            check("round_win_l", win_l, 1);
            check("round_score_l", score_l, k);
            key_l = 1'b0; edge_l = 1'b0;
            for (int i = 0; i < 15; i++) step();
            check("round_game_over_pre", game_over, 0);
            step();
            if (k < 7) begin
                check("round_win_l_clr", win_l, 0);
                check("round_fr", field_reset, 1);
                for (int i = 0; i < 5; i++) step();
            end
        end
        check("over_game_over", game_over, 1);
        check("over_win_l", win_l, 1);
        check("over_score_r", score_r, 1);
        for (int i = 0; i < 20; i++) step();
        check("over_hold_win_l", win_l, 1);
        key_r = 1'b1; step();
        check("over_solo_r", r, 0);
        check("over_solo_win_r", win_r, 0);
        check("over_solo_score_l", score_l, 7);
        check("over_solo_game_over", game_over, 1);
        key_r = 1'b0; step();
        key_l = 1'b1; key_r = 1'b1; step();
        check("restart_score_l", score_l, 0);
        check("restart_score_r", score_r, 0);
        check("restart_game_over", game_over, 0);
        check("restart_win_l", win_l, 0);
        check("restart_fr", field_reset, 1);
        key_l = 1'b0; key_r = 1'b0; step();
        check("restart_fr_off", field_reset, 0);

        // asynchronous reset during a win hold
        for (int i = 0; i < 4; i++) step();
        edge_r = 1'b1; key_r = 1'b1; step();
        check("pre_reset_win_r", win_r, 1);
        check("pre_reset_score_r", score_r, 1);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("async_win_r", win_r, 0);
        check("async_score_r", score_r, 0);
        check("async_fr", field_reset, 1);
        check("async_r", r, 0);
        check("async_game_over", game_over, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
